// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: queues host LCD command codes and issues them one at a time to a busy/done LCD controller.
// Define LCD_CMD_SCHED_TIMEOUT_EN to add a wait-state watchdog and the err_timeout output.
module lcd_cmd_sched #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_push,
    output logic       host_full,
    input  logic       busy,
    input  logic       done,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [4:0] q_count,
    output logic [7:0] cmds_done,
    output logic       err_illegal,
    output logic       err_overflow,
`ifdef LCD_CMD_SCHED_TIMEOUT_EN
    output logic       err_timeout,
`endif
    output logic [1:0] fsm_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          legal;
    logic          push_ok;
    logic          pop;
    logic          finish;
    logic          timeout_hit;
    logic          unused_done;

    // done carries no extra meaning: completion is the falling busy in WAIT_DONE.
    assign unused_done = done;

    // Full is taken from the registered count, so a same-cycle pop never rescues a push.
    assign host_full = (count == 5'(DEPTH));
    assign q_count   = count;
    assign legal     = (host_cmd <= 4'hB);
    assign push_ok   = host_push && !host_full && legal;
    assign pop       = (state == IDLE) && (count != 5'd0) && !busy;
    assign finish    = (state == WAIT_DONE) && !busy;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd          <= '0;
            cmds_done    <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cmd    <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (finish) begin
                cmds_done <= cmds_done + 8'd1;
            end
            if (host_push && !legal) begin
                err_illegal <= 1'b1;
            end
            if (host_push && host_full) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef LCD_CMD_SCHED_TIMEOUT_EN
    logic [7:0] wd;
    logic       in_wait;

    assign in_wait     = (state == WAIT_BUSY) || (state == WAIT_DONE);
    // wd is 0 on the first wait cycle, so 254 marks the 255th cycle spent waiting.
    assign timeout_hit = (wd >= 8'd254) &&
                         (((state == WAIT_BUSY) && !busy) || ((state == WAIT_DONE) && busy));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!in_wait) begin
                wd <= 8'd0;
            end else if (wd != 8'hFF) begin
                wd <= wd + 8'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pop) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy) begin
                    state_next = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        fsm_state = state;
    end

endmodule
